// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: digit count, index type and segment patterns.
// Segment order throughout is {g,f,e,d,c,b,a}, active high.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    localparam logic [6:0] SEG_PATTERN [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    function automatic logic [3:0] digit_nibble(input logic [11:0] value, input digit_idx_t idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to seven-segment decode; non-decimal nibbles show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Decimal digits use the pattern table, everything else renders "-"
    always_comb begin
        o_seg = SEG_OFF;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_PATTERN[i_bcd];
        end else begin
            o_seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Three-digit seven-segment scan controller with frame-aligned double-buffered value.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero segments.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [11:0] DIN,
    output logic        PEND,
    output logic        ACK,
    output logic [1:0]  SEL,
    output logic        D1,
    output logic        D2,
    output logic        D3,
    output logic [6:0]  SEG,
    output logic        FRAME
);

    localparam int              PW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(DIV - 1);
    localparam digit_idx_t      LAST_DIGIT  = digit_idx_t'(NUM_DIGITS - 1);

    logic [PW-1:0] r_presc;
    digit_idx_t    r_sel;
    logic [11:0]   r_disp;
    logic [11:0]   r_buf;
    logic          r_pend;
    logic          r_ack;
    logic          r_frame;
    logic [2:0]    r_den;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic          w_boundary;
    logic [PW-1:0] w_presc_nxt;
    digit_idx_t    w_sel_nxt;
    logic [11:0]   w_disp_nxt;
    logic          w_en_nxt;
    logic [2:0]    w_den_nxt;
    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic [6:0]    w_seg_nxt;
    logic          w_lz_blank;

    // Enables open only after the anti-ghosting blank interval of the upcoming slot cycle
    generate
        if (BLANK == 0) begin : g_no_blank
            assign w_en_nxt = 1'b1;
        end else begin : g_blank
            assign w_en_nxt = (w_presc_nxt >= PW'(BLANK));
        end
    endgenerate

    // Next scan position and next displayed value; a LOAD on the boundary bypasses the buffer
    always_comb begin
        w_wrap      = (r_presc == PRESC_LAST);
        w_boundary  = w_wrap && (r_sel == LAST_DIGIT);
        w_presc_nxt = r_presc;
        w_sel_nxt   = r_sel;
        w_disp_nxt  = r_disp;
        if (w_wrap) begin
            w_presc_nxt = '0;
            if (r_sel == LAST_DIGIT) begin
                w_sel_nxt = 2'd0;
            end else begin
                w_sel_nxt = r_sel + 2'd1;
            end
        end else begin
            w_presc_nxt = r_presc + PW'(1);
        end
        if (w_boundary && LOAD) begin
            w_disp_nxt = DIN;
        end else if (w_boundary && r_pend) begin
            w_disp_nxt = r_buf;
        end else begin
            w_disp_nxt = r_disp;
        end
    end

    assign w_nib = digit_nibble(w_disp_nxt, w_sel_nxt);

    bcd_to_seg u_dec (
        .i_bcd (w_nib),
        .o_seg (w_dec)
    );

    // Output pattern for the upcoming cycle, including optional leading-zero suppression
    always_comb begin
        w_lz_blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if ((w_sel_nxt == 2'd2) && (w_disp_nxt[11:8] == 4'd0)) begin
            w_lz_blank = 1'b1;
        end else if ((w_sel_nxt == 2'd1) && (w_disp_nxt[11:4] == 8'd0)) begin
            w_lz_blank = 1'b1;
        end else begin
            w_lz_blank = 1'b0;
        end
`else
        w_lz_blank = 1'b0;
`endif
        if (w_lz_blank) begin
            w_seg_nxt = SEG_OFF;
        end else begin
            w_seg_nxt = w_dec;
        end
        if (w_en_nxt) begin
            w_den_nxt = 3'b001 << w_sel_nxt;
        end else begin
            w_den_nxt = 3'b000;
        end
    end

    // Scan state, value buffers and registered display outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
            r_sel   <= 2'd0;
            r_disp  <= 12'h000;
            r_buf   <= 12'h000;
            r_pend  <= 1'b0;
            r_ack   <= 1'b0;
            r_frame <= 1'b0;
            r_den   <= 3'b000;
            r_seg   <= 7'b0000000;
        end else begin
            r_presc <= w_presc_nxt;
            r_sel   <= w_sel_nxt;
            r_disp  <= w_disp_nxt;
            r_frame <= w_boundary;
            r_ack   <= w_boundary && (LOAD || r_pend);
            r_den   <= w_den_nxt;
            r_seg   <= w_seg_nxt;
            if (LOAD) begin
                r_buf <= DIN;
            end
            if (w_boundary) begin
                r_pend <= 1'b0;
            end else if (LOAD) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign PEND  = r_pend;
    assign ACK   = r_ack;
    assign SEL   = r_sel;
    assign D1    = r_den[0];
    assign D2    = r_den[1];
    assign D3    = r_den[2];
    assign SEG   = r_seg;
    assign FRAME = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl with DIV=8, BLANK=2.
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [11:0] din;
    logic        pend, ack, d1, d2, d3, frame;
    logic [1:0]  sel;
    logic [6:0]  seg;

    int          n_checks = 0;
    int          n_errors = 0;

    int          m_p, m_s;
    logic [11:0] m_disp, m_buf;
    logic        m_pend, m_ack, m_frame;

    seven_seg_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
        .CLK(clk), .RST_N(rst_n), .LOAD(load), .DIN(din),
        .PEND(pend), .ACK(ack), .SEL(sel),
        .D1(d1), .D2(d2), .D3(d3), .SEG(seg), .FRAME(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int s);
        logic [3:0] nib;
        logic [6:0] pat;
        nib = 4'(m_disp >> (4 * s));
        case (nib)
            4'd0: pat = 7'b0111111;
            4'd1: pat = 7'b0000110;
            4'd2: pat = 7'b1011011;
            4'd3: pat = 7'b1001111;
            4'd4: pat = 7'b1100110;
            4'd5: pat = 7'b1101101;
            4'd6: pat = 7'b1111101;
            4'd7: pat = 7'b0000111;
            4'd8: pat = 7'b1111111;
            4'd9: pat = 7'b1101111;
            default: pat = 7'b1000000;
        endcase
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (s == 2 && m_disp[11:8] == 4'd0) pat = 7'b0000000;
        if (s == 1 && m_disp[11:4] == 8'd0) pat = 7'b0000000;
`endif
        return pat;
    endfunction

    // Advance one clock; the reference follows the behaviour described for the block
    task automatic tick();
        logic boundary;
        @(posedge clk);
        boundary = (m_p == 7 && m_s == 2);
        m_ack    = boundary && (load || m_pend);
        m_frame  = boundary;
        if (boundary) begin
            if (load) m_disp = din;
            else if (m_pend) m_disp = m_buf;
            m_pend = 1'b0;
        end else if (load) begin
            m_buf  = din;
            m_pend = 1'b1;
        end
        if (m_p == 7) begin
            m_p = 0;
            m_s = (m_s == 2) ? 0 : m_s + 1;
        end else begin
            m_p = m_p + 1;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":sel"},   12'(sel),   12'(m_s));
        chk({tag, ":d1"},    12'(d1),    12'(m_s == 0 && m_p >= 2));
        chk({tag, ":d2"},    12'(d2),    12'(m_s == 1 && m_p >= 2));
        chk({tag, ":d3"},    12'(d3),    12'(m_s == 2 && m_p >= 2));
        chk({tag, ":seg"},   12'(seg),   12'(exp_seg(m_s)));
        chk({tag, ":frame"}, 12'(frame), 12'(m_frame));
        chk({tag, ":ack"},   12'(ack),   12'(m_ack));
        chk({tag, ":pend"},  12'(pend),  12'(m_pend));
    endtask

    task automatic run_to(input int s, input int p, input string tag);
        int n;
        n = 0;
        while (!(m_s == s && m_p == p) && n < 40) begin
            tick();
            check_all(tag);
            n++;
        end
        if (!(m_s == s && m_p == p)) begin
            n_errors++;
            $error("FAIL %s_reach: observed sel %0d slot %0d expected sel %0d slot %0d", tag, m_s, m_p, s, p);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_s = 0; m_disp = 12'h000; m_buf = 12'h000;
        m_pend = 1'b0; m_ack = 1'b0; m_frame = 1'b0;
    endtask

    initial begin
        int frame_cnt, d1_cnt, ack_cnt;
        rst_n = 1'b0; load = 1'b0; din = 12'h000;
        model_reset();
        #2;
        chk("rst_sel", 12'(sel), 12'h0);
        chk("rst_den", 12'({d3, d2, d1}), 12'h0);
        chk("rst_seg", 12'(seg), 12'h0);
        chk("rst_hs",  12'({pend, ack, frame}), 12'h0);
        #10 rst_n = 1'b1;

        // Free-running scan with nothing loaded
        frame_cnt = 0; d1_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            check_all("scan");
            frame_cnt += int'(frame);
            d1_cnt    += int'(d1);
        end
        chk("scan_frames", 12'(frame_cnt), 12'd2);
        chk("scan_d1_cycles", 12'(d1_cnt), 12'd12);
        chk("scan_seg_zero", 12'(seg), 12'(7'b0111111));

        // Mid-frame load of 0x123
        run_to(1, 3, "l123");
        load = 1'b1; din = 12'h123;
        tick(); check_all("l123_cap");
        chk("l123_pend", 12'(pend), 12'h1);
        load = 1'b0;
        run_to(0, 0, "l123_wait");
        chk("l123_ack",   12'(ack),   12'h1);
        chk("l123_frame", 12'(frame), 12'h1);
        chk("l123_pend0", 12'(pend),  12'h0);
        run_to(0, 2, "l123");
        chk("l123_ones", 12'(seg), 12'(7'b1001111));
        run_to(1, 2, "l123");
        chk("l123_tens", 12'(seg), 12'(7'b1011011));
        run_to(2, 2, "l123");
        chk("l123_hund", 12'(seg), 12'(7'b0000110));

        // Two loads before one boundary: last write wins, single ACK
        run_to(0, 3, "l789");
        load = 1'b1; din = 12'h456; tick(); check_all("l456_cap"); load = 1'b0;
        run_to(1, 3, "l789");
        load = 1'b1; din = 12'h789; tick(); check_all("l789_cap"); load = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); check_all("l789_wait");
            ack_cnt += int'(ack);
        end
        chk("l789_single_ack", 12'(ack_cnt), 12'd1);
        run_to(0, 2, "l789");
        chk("l789_ones", 12'(seg), 12'(7'b1101111));
        run_to(1, 2, "l789");
        chk("l789_tens", 12'(seg), 12'(7'b1111111));
        run_to(2, 2, "l789");
        chk("l789_hund", 12'(seg), 12'(7'b0000111));

        // Load exactly on the frame boundary cycle
        run_to(2, 7, "l3a0");
        load = 1'b1; din = 12'h3A0;
        tick(); check_all("l3a0_cap");
        chk("l3a0_ack",   12'(ack),   12'h1);
        chk("l3a0_frame", 12'(frame), 12'h1);
        chk("l3a0_pend",  12'(pend),  12'h0);
        load = 1'b0;
        run_to(0, 2, "l3a0");
        chk("l3a0_ones", 12'(seg), 12'(7'b0111111));
        run_to(1, 2, "l3a0");
        chk("l3a0_dash", 12'(seg), 12'(7'b1000000));
        run_to(2, 2, "l3a0");
        chk("l3a0_hund", 12'(seg), 12'(7'b1001111));

        // Asynchronous reset in the middle of the tens slot
        run_to(1, 4, "rst_mid");
        chk("pre_rst_d2", 12'(d2), 12'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 12'(sel), 12'h0);
        chk("mid_rst_den", 12'({d3, d2, d1}), 12'h0);
        chk("mid_rst_seg", 12'(seg), 12'h0);
        chk("mid_rst_hs",  12'({pend, ack, frame}), 12'h0);
        #2 rst_n = 1'b1;
        model_reset();
        tick(); check_all("post_rst");
        chk("post_rst_sel", 12'(sel), 12'h0);
        run_to(0, 2, "post_rst");
        chk("post_rst_ones", 12'(seg), 12'(7'b0111111));

        // Value 0x007 exercises leading-zero handling
        load = 1'b1; din = 12'h007; tick(); check_all("l007_cap"); load = 1'b0;
        run_to(0, 0, "l007_wait");
        chk("l007_ack", 12'(ack), 12'h1);
        run_to(0, 2, "l007");
        chk("l007_ones", 12'(seg), 12'(7'b0000111));
        run_to(1, 2, "l007");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        chk("l007_tens", 12'(seg), 12'(7'b0000000));
`else
        chk("l007_tens", 12'(seg), 12'(7'b0111111));
`endif
        chk("l007_d2", 12'(d2), 12'h1);
        run_to(2, 2, "l007");
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        chk("l007_hund", 12'(seg), 12'(7'b0000000));
`else
        chk("l007_hund", 12'(seg), 12'(7'b0111111));
`endif
        chk("l007_d3", 12'(d3), 12'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the three-digit seven-segment display.
- Generates the digit-select sequence 0→1→2→0, one-hot digit enables D1..D3, and the matching segment pattern.
- Holds a double-buffered 3-digit BCD value and updates it only on frame boundaries, so a digit never tears mid-frame.
- Sits between the value-producing logic (counters, UI) and the display pins.

Parameters:
DIV, 1000, clock cycles per digit slot (≥2)
BLANK, 16, cycles at start of each slot with all digits off, for anti-ghosting (0 ≤ BLANK < DIV)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
LOAD  in  1  strobe: capture DIN this cycle
DIN  in  12  BCD value; [3:0] ones, [7:4] tens, [11:8] hundreds
PEND  out  1  a captured value is waiting for the next frame boundary
ACK  out  1  one-cycle pulse: a new value became the displayed value
SEL  out  2  current digit index 0..2 (drives the existing switcher's select input)
D1  out  1  digit enable, ones (active high)
D2  out  1  digit enable, tens
D3  out  1  digit enable, hundreds
SEG  out  7  segments {g,f,e,d,c,b,a}, active high
FRAME  out  1  one-cycle pulse when SEL wraps 2→0

Behaviour:
- Reset (async, RST_N=0):
  - Prescaler=0, SEL=0, displayed value=0x000, pending buffer=0x000.
  - PEND=0, ACK=0, FRAME=0, D1..D3=0, SEG=0.
  - Reset mid-slot aborts the slot immediately; scanning restarts at SEL=0, slot cycle 0, after release.
- Prescaler:
  - Counts 0..DIV-1; at DIV-1 wraps to 0 and SEL advances.
  - SEL sequence is 0→1→2→0; value 3 never appears.
- Frame boundary = the cycle where the prescaler wraps with SEL=2. On the next edge:
  - SEL=0.
  - FRAME=1 for one cycle.
- Outputs are registered and reflect the current slot state:
  - Slot cycles 0..BLANK-1: D1=D2=D3=0; SEG already shows the new digit's pattern.
  - Slot cycles BLANK..DIV-1: exactly one of D1/D2/D3 high, per SEL (0→D1, 1→D2, 2→D3).
  - BLANK=0: no blank interval.
- Load handshake:
  - LOAD=1 captures DIN into the pending buffer and sets PEND=1 on the next edge.
  - LOAD while PEND=1 overwrites the buffer; last write wins; no error.
  - At a frame boundary with PEND=1: displayed←pending, PEND←0, ACK=1 for one cycle, coincident with FRAME.
- Simultaneous LOAD and frame boundary: DIN bypasses the buffer and becomes the displayed value directly; PEND stays 0; ACK=1.
- No LOAD pending at a boundary: displayed value unchanged, ACK=0.
- Decode:
  - Nibbles 0–9 use the standard seven-segment patterns.
  - Nibbles A–F display "-" (SEG=7'b1000000).
- Latency: LOAD to visible on display is at most 3*DIV+1 cycles.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Hundreds=0 → SEG=0 during the D3 slot.
  - Hundreds=0 and tens=0 → SEG=0 during the D2 slot as well.
  - Ones digit is always shown.
  - D1..D3 timing is unchanged; only SEG is forced to 0.
- Undefined: all three digits always display, including leading zeros.

Decomposition:
- Shared package seven_seg_pkg holds:
  - SEG_PATTERN constant array for 0–9.
  - SEG_DASH and SEG_OFF constants.
  - NUM_DIGITS=3.
  - typedef digit_idx_t (2-bit).
- One sub-module, bcd_to_seg: combinational nibble→7-bit decode, also reused by other display blocks.
- Controller owns the prescaler, SEL counter, buffers and output registers.

Test Plan (DIV=8, BLANK=2):
- Release reset, no LOAD → SEL steps 0,1,2,0 every 8 cycles; FRAME pulses every 24 cycles; each D high 6 of 8 cycles; SEG=7'b0111111 ("0") throughout.
- LOAD with DIN=0x123 mid-frame → PEND=1; at the next boundary ACK=FRAME=1 and PEND=0; D1 slot SEG=7'b1001111 ("3"), D2 "2"=7'b1011011, D3 "1"=7'b0000110.
- LOAD 0x456, then LOAD 0x789 before the boundary → only 0x789 is displayed; a single ACK.
- LOAD 0x3A0 in the exact boundary cycle → applied without waiting a frame; PEND stays 0; tens slot shows SEG=7'b1000000.
- Assert RST_N=0 mid-slot with SEL=1 → all outputs 0 immediately; after release, SEL=0 and displayed value 0x000.
- SEVEN_SEG_LEADING_ZERO_BLANK_EN, DIN=0x007 → D3 and D2 slots SEG=0; D1 slot SEG=7'b0000111.
